fp_mul_arbiter: RTL

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that time-shares one floating-point multiplier among NREQ
// requesters, with a completion watchdog and an enforced low gap on mul_str.
module fp_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned GAP     = 3,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   opa,
  input  logic [32*NREQ-1:0]   opb,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_str,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_out,
  input  logic                 mul_done,
  input  logic                 mul_error
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_e;

  state_e            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     idx_q;
  logic [TW-1:0]     wdog_q;
  logic [GW-1:0]     gcnt_q;
  logic              init_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              busy_q;
  logic              mul_str_q;
  logic [31:0]       mul_a_q;
  logic [31:0]       mul_b_q;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     ptr_d;

  // Round-robin search: first active request at or above ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);

  // The IDLE cycle before a grant is the last low cycle of the gap, so GAP
  // itself exits one count early to keep mul_str low for exactly GAP cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      wdog_q      <= '0;
      gcnt_q      <= '0;
      init_q      <= 1'b1;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mul_str_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (init_q) begin
            // First cycle out of reset: run one gap before any grant.
            init_q  <= 1'b0;
            gcnt_q  <= '0;
            state_q <= S_GAP;
            busy_q  <= 1'b1;
          end else if (win_found) begin
            idx_q     <= win_idx;
            gnt_q     <= NREQ'(1) << win_idx;
            mul_a_q   <= opa[32*win_idx +: 32];
            mul_b_q   <= opb[32*win_idx +: 32];
            mul_str_q <= 1'b1;
            wdog_q    <= '0;
            state_q   <= S_WAIT;
            busy_q    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mul_done || (wdog_q == TW'(TIMEOUT))) begin
            rsp_data_q  <= mul_done ? mul_out : 32'h0;
            rsp_err_q   <= mul_done ? mul_error : 1'b1;
            rsp_valid_q <= NREQ'(1) << idx_q;
            mul_str_q   <= 1'b0;
            gnt_q       <= '0;
            ptr_q       <= ptr_d;
            gcnt_q      <= '0;
            state_q     <= S_GAP;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
        end
        S_GAP: begin
          if (gcnt_q == GW'(GAP - 2)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign mul_str   = mul_str_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule
